uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
Parametrised UART receive controller for the UART_RX path. It contains the frame FSM, edge/bit counters, a 3-sample majority sampler, the deserializer and the parity/stop checkers in one block. It generalises the fixed 8-bit receiver to DATA_W data bits, even/odd parity selection, 1 or 2 stop bits, and registered error pulses. It sits between the RX_IN synchroniser and the RX FIFO / SYS_CTRL.

Parameters:
DATA_W, 8, number of data bits per frame (legal 5..9)
PRESC_W, 6, width of the prescale input and the edge counter

Ports:
clk  in  1  receiver oversampling clock
rst  in  1  asynchronous, active-high reset
rx_in  in  1  serial line, already synchronised to clk; idle high
par_en  in  1  1 = frame carries a parity bit
par_typ  in  1  0 = even parity, 1 = odd parity
stop2  in  1  1 = two stop bits
prescale  in  PRESC_W  oversampling ratio; legal 8, 16, 32
p_data  out  DATA_W  last correctly received word, LSB = first bit received
data_valid  out  1  one-cycle pulse: p_data updated
par_err  out  1  one-cycle pulse: parity mismatch, frame dropped
stp_err  out  1  one-cycle pulse: stop bit sampled low, frame dropped
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - FSM goes to IDLE; all counters are cleared.
  - p_data = 0; data_valid, par_err, stp_err and busy = 0.
- Configuration latch: prescale, par_en, par_typ and stop2 are latched on the IDLE->START transition. Changes mid-frame are ignored.
- Prescale values below 8 are treated as 8.
- Timing counters:
  - edge_cnt counts 0..P-1 within each bit, where P is the latched prescale.
  - bit_cnt counts the bits within the current state.
- Sampler:
  - Takes rx_in at edge_cnt = P/2-1, P/2 and P/2+1.
  - bit value = majority of the three samples, registered at edge_cnt = P/2+1.
  - Decisions in the state list below are taken at edge_cnt = P/2+2. This is the "sample point".
- States (binary encoding, 3 bits):
  - IDLE: rx_in = 0 -> START, with edge_cnt cleared to 0 on that cycle. Otherwise stay.
  - START:
    - Majority = 1 at the sample point -> glitch: go to IDLE, no error pulse.
    - Otherwise -> DATA at the end of the bit (edge_cnt = P-1).
  - DATA:
    - Shift the majority value into the shift register at each sample point, LSB first.
    - After DATA_W bits, at edge_cnt = P-1: go to PARITY if par_en = 1, else to STOP.
  - PARITY:
    - At the sample point, compare the received bit with the computed parity: XOR of the data bits, XOR par_typ.
    - Mismatch sets an internal pe flag.
    - Then go to STOP at edge_cnt = P-1.
  - STOP:
    - Check majority = 1 at the sample point of each stop bit (1 or 2 bits per stop2).
    - A low stop bit resolves the frame immediately at that sample point.
    - Otherwise the frame resolves at the sample point of the last stop bit.
    - The FSM returns to IDLE on the resolving cycle, so it can detect a start edge within the back half of the stop bit.
- Frame resolution (registered outputs, asserted on the cycle after the resolving sample point, for exactly 1 cycle):
  - Stop fail: stp_err = 1. par_err = pe is also pulsed in the same cycle if pe is set.
  - Stop ok, pe = 1: par_err = 1.
  - Stop ok, pe = 0: p_data <= shift register; data_valid = 1.
  - data_valid is never asserted together with either error.
- p_data holds its value until the next valid frame. Dropped frames do not alter it.
- pe is cleared on entry to START.
- Shift register width:
  - DATA_W = 9 is legal.
  - Counters are sized so that DATA_W + parity + 2 stop bits fit without wrap.
- rx_in held low permanently: START -> DATA -> ... -> stp_err pulse -> IDLE. The FSM then re-enters START while the line remains low, with a new stp_err per frame time. No lock-up.

Decomposition:
- Shared package uart_rx_pkg:
  - state localparams IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4
  - parity-type constants PAR_EVEN=0, PAR_ODD=1
  - minimum prescale constant 8
- One sub-module, uart_rx_sampler: holds edge_cnt, the three sample registers and the majority output, with a sample_done strobe at P/2+1.
- The FSM, deserializer and checkers stay in uart_rx_ctrl.

Test Plan:
- DATA_W=8, P=8, par_en=0, stop2=0; send 0xA5 -> data_valid pulse, p_data=0xA5, no errors, busy low afterward.
- DATA_W=8, P=16, par_en=1, par_typ=0; send 0x3C with a wrong parity bit (1) -> par_err pulse only, p_data keeps the previous 0xA5.
- DATA_W=7, P=32, par_en=1, par_typ=1, stop2=1; send 0x55 with odd parity, second stop bit driven low -> stp_err pulse, no data_valid.
- Drive rx_in low for 3 clk at P=16, then high -> returns to IDLE, no pulses; a following frame 0x81 -> data_valid, p_data=0x81.
- Back-to-back frames 0x01 then 0xFE with the next start edge at edge_cnt = P-2 of the stop bit -> two data_valid pulses with the correct words; change prescale mid-frame, with no effect on the current frame.
- Assert rst mid-DATA of frame 0x77 -> all outputs 0 immediately, busy = 0; the next frame 0x12 is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller and its sampler.
// State encoding is fixed binary so it can be probed on a debug bus.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam int   MIN_PRESC = 8;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter plus 3-sample majority voter around the bit centre.
// The majority is registered one edge after the centre, flagged by o_sampleDone.
module uart_rx_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_rx,
    input  logic [PRESC_W-1:0] i_presc,
    output logic [PRESC_W-1:0] o_edgeCnt,
    output logic               o_majority,
    output logic               o_sampleDone
);

    logic [PRESC_W-1:0] r_edgeCnt;
    logic               r_s0;
    logic               r_s1;
    logic               r_majority;
    logic [PRESC_W-1:0] w_half;
    logic               w_sampleDone;

    assign w_half       = i_presc >> 1;
    assign w_sampleDone = i_en && (r_edgeCnt == w_half + 1'b1);

    // The third sample is the live line value, voted and stored in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_edgeCnt  <= '0;
            r_s0       <= 1'b0;
            r_s1       <= 1'b0;
            r_majority <= 1'b0;
        end else if (!i_en) begin
            r_edgeCnt <= '0;
        end else begin
            r_edgeCnt <= (r_edgeCnt == i_presc - 1'b1) ? '0 : r_edgeCnt + 1'b1;
            if (r_edgeCnt == w_half - 1'b1) begin
                r_s0 <= i_rx;
            end
            if (r_edgeCnt == w_half) begin
                r_s1 <= i_rx;
            end
            if (w_sampleDone) begin
                r_majority <= (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);
            end
        end
    end

    assign o_edgeCnt    = r_edgeCnt;
    assign o_majority   = r_majority;
    assign o_sampleDone = w_sampleDone;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, deserializer, parity and stop checking.
// Configuration is frozen at each start edge so mid-frame changes cannot corrupt a frame.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx_in,
    input  logic               par_en,
    input  logic               par_typ,
    input  logic               stop2,
    input  logic [PRESC_W-1:0] prescale,
    output logic [DATA_W-1:0]  p_data,
    output logic               data_valid,
    output logic               par_err,
    output logic               stp_err,
    output logic               busy
);

    localparam int BIT_W = $clog2(DATA_W + 4);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);

    state_t              r_state;
    state_t              w_next;
    logic [PRESC_W-1:0]  r_presc;
    logic                r_parEn;
    logic                r_parTyp;
    logic                r_stop2;
    logic [BIT_W-1:0]    r_bitCnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_pe;
    logic                r_samplePt;
    logic [DATA_W-1:0]   r_pData;
    logic                r_dataValid;
    logic                r_parErr;
    logic                r_stpErr;

    logic [PRESC_W-1:0]  w_prescEff;
    logic [PRESC_W-1:0]  w_edgeCnt;
    logic                w_majority;
    logic                w_sampleDone;
    logic                w_bitEnd;
    logic                w_lastStop;
    logic                w_expPar;
    logic                w_latch;
    logic                w_shiftEn;
    logic                w_parChk;
    logic                w_bitInc;
    logic                w_bitClr;
    logic                w_resolve;
    logic                w_stopFail;

    assign w_prescEff = (prescale < PRESC_W'(MIN_PRESC)) ? PRESC_W'(MIN_PRESC) : prescale;
    assign w_bitEnd   = (w_edgeCnt == r_presc - 1'b1);
    assign w_lastStop = (r_bitCnt == (r_stop2 ? BIT_W'(1) : BIT_W'(0)));
    assign w_expPar   = (^r_shift) ^ (r_parTyp == PAR_ODD);

    uart_rx_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .i_en         (r_state != IDLE),
        .i_rx         (rx_in),
        .i_presc      (r_presc),
        .o_edgeCnt    (w_edgeCnt),
        .o_majority   (w_majority),
        .o_sampleDone (w_sampleDone)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Returning to IDLE on the resolving sample lets the back half of a stop bit carry the next start edge.
    always_comb begin
        w_next     = r_state;
        w_latch    = 1'b0;
        w_shiftEn  = 1'b0;
        w_parChk   = 1'b0;
        w_bitInc   = 1'b0;
        w_bitClr   = 1'b0;
        w_resolve  = 1'b0;
        w_stopFail = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rx_in) begin
                    w_next  = START;
                    w_latch = 1'b1;
                end
            end
            START: begin
                if (r_samplePt && w_majority) begin
                    w_next = IDLE;
                end else if (w_bitEnd) begin
                    w_next   = DATA;
                    w_bitClr = 1'b1;
                end
            end
            DATA: begin
                w_shiftEn = r_samplePt;
                if (w_bitEnd) begin
                    if (r_bitCnt == LAST_DATA) begin
                        w_next   = r_parEn ? PARITY : STOP;
                        w_bitClr = 1'b1;
                    end else begin
                        w_bitInc = 1'b1;
                    end
                end
            end
            PARITY: begin
                w_parChk = r_samplePt;
                if (w_bitEnd) begin
                    w_next   = STOP;
                    w_bitClr = 1'b1;
                end
            end
            STOP: begin
                if (r_samplePt) begin
                    if (!w_majority) begin
                        w_next     = IDLE;
                        w_resolve  = 1'b1;
                        w_stopFail = 1'b1;
                    end else if (w_lastStop) begin
                        w_next    = IDLE;
                        w_resolve = 1'b1;
                    end
                end else if (w_bitEnd) begin
                    w_bitInc = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc    <= PRESC_W'(MIN_PRESC);
            r_parEn    <= 1'b0;
            r_parTyp   <= PAR_EVEN;
            r_stop2    <= 1'b0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_pe       <= 1'b0;
            r_samplePt <= 1'b0;
        end else begin
            r_samplePt <= w_sampleDone;
            if (w_latch) begin
                r_presc  <= w_prescEff;
                r_parEn  <= par_en;
                r_parTyp <= par_typ;
                r_stop2  <= stop2;
                r_pe     <= 1'b0;
                r_bitCnt <= '0;
            end else if (w_bitClr) begin
                r_bitCnt <= '0;
            end else if (w_bitInc) begin
                r_bitCnt <= r_bitCnt + 1'b1;
            end
            if (w_shiftEn) begin
                r_shift <= {w_majority, r_shift[DATA_W-1:1]};
            end
            if (w_parChk && (w_majority != w_expPar)) begin
                r_pe <= 1'b1;
            end
        end
    end

    // A stop failure reports any pending parity error alongside it; only clean frames reach p_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pData     <= '0;
            r_dataValid <= 1'b0;
            r_parErr    <= 1'b0;
            r_stpErr    <= 1'b0;
        end else begin
            r_dataValid <= w_resolve && !w_stopFail && !r_pe;
            r_parErr    <= w_resolve && r_pe;
            r_stpErr    <= w_resolve && w_stopFail;
            if (w_resolve && !w_stopFail && !r_pe) begin
                r_pData <= r_shift;
            end
        end
    end

    assign p_data     = r_pData;
    assign data_valid = r_dataValid;
    assign par_err    = r_parErr;
    assign stp_err    = r_stpErr;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: an 8-bit and a 7-bit receiver driven from one serial line,
// outcomes predicted frame-by-frame from the parity/stop rules and counted pulse totals.
module tb_uart_rx_ctrl;

    localparam int PRESC_W = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               line;
    logic               selB;
    logic               rxA;
    logic               rxB;
    logic               parEn;
    logic               parTyp;
    logic               stop2;
    logic [PRESC_W-1:0] prescale;

    logic [7:0] pDataA;
    logic       dvA, peA, seA, busyA;
    logic [6:0] pDataB;
    logic       dvB, peB, seB, busyB;

    int dvCntA = 0, peCntA = 0, seCntA = 0;
    int dvCntB = 0, peCntB = 0, seCntB = 0;
    int overlapCnt = 0;
    logic [8:0] gotA[$];

    int expDvA = 0, expPeA = 0, expSeA = 0;
    int expDvB = 0, expPeB = 0, expSeB = 0;
    logic [8:0] expDataA = '0;
    logic [8:0] expDataB = '0;
    logic [8:0] expWordsA[$];
    int rdA = 0;

    int checks = 0;
    int passes = 0;

    assign rxA = selB ? 1'b1 : line;
    assign rxB = selB ? line : 1'b1;

    always #5 clk = ~clk;

    uart_rx_ctrl #(.DATA_W(8), .PRESC_W(PRESC_W)) u_dutA (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rxA),
        .par_en     (parEn),
        .par_typ    (parTyp),
        .stop2      (stop2),
        .prescale   (prescale),
        .p_data     (pDataA),
        .data_valid (dvA),
        .par_err    (peA),
        .stp_err    (seA),
        .busy       (busyA)
    );

    uart_rx_ctrl #(.DATA_W(7), .PRESC_W(PRESC_W)) u_dutB (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rxB),
        .par_en     (parEn),
        .par_typ    (parTyp),
        .stop2      (stop2),
        .prescale   (prescale),
        .p_data     (pDataB),
        .data_valid (dvB),
        .par_err    (peB),
        .stp_err    (seB),
        .busy       (busyB)
    );

    // Pulse counters: one-cycle pulses are required, so every high cycle counts.
    always @(negedge clk) begin
        if (dvA) begin
            dvCntA <= dvCntA + 1;
            gotA.push_back({1'b0, pDataA});
        end
        if (peA) peCntA <= peCntA + 1;
        if (seA) seCntA <= seCntA + 1;
        if (dvB) dvCntB <= dvCntB + 1;
        if (peB) peCntB <= peCntB + 1;
        if (seB) seCntB <= seCntB + 1;
        if ((dvA && (peA || seA)) || (dvB && (peB || seB))) overlapCnt <= overlapCnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame and records the outcome the receive rules predict for it.
    task automatic applyStimulus(input bit toB, input int nbits, input logic [8:0] data, input int p,
                                 input bit pEn, input bit pTyp, input bit s2, input bit badPar,
                                 input int stopLow, input bit shortStop);
        int ones;
        int nStop;
        logic parBit;
        logic [8:0] word;
        bit expPe;
        bit expSe;
        selB     = toB;
        prescale = PRESC_W'(p);
        parEn    = pEn;
        parTyp   = pTyp;
        stop2    = s2;
        ones = 0;
        word = '0;
        for (int i = 0; i < nbits; i++) begin
            ones += int'(data[i]);
            word[i] = data[i];
        end
        parBit = logic'(ones % 2) ^ pTyp;
        if (badPar) parBit = ~parBit;
        line = 1'b0;
        ticks(p);
        prescale = PRESC_W'($urandom);
        parEn    = 1'($urandom);
        parTyp   = 1'($urandom);
        stop2    = 1'($urandom);
        for (int i = 0; i < nbits; i++) begin
            line = data[i];
            ticks(p);
        end
        if (pEn) begin
            line = parBit;
            ticks(p);
        end
        prescale = PRESC_W'(p);
        parEn    = pEn;
        parTyp   = pTyp;
        stop2    = s2;
        nStop = s2 ? 2 : 1;
        for (int i = 0; i < nStop; i++) begin
            line = (i == stopLow) ? 1'b0 : 1'b1;
            ticks((shortStop && i == nStop - 1) ? p - 1 : p);
        end
        line = 1'b1;
        expPe = pEn && badPar;
        expSe = (stopLow >= 0);
        if (toB) begin
            if (expPe) expPeB++;
            if (expSe) expSeB++;
            if (!expPe && !expSe) begin
                expDvB++;
                expDataB = word;
            end
        end else begin
            if (expPe) expPeA++;
            if (expSe) expSeA++;
            if (!expPe && !expSe) begin
                expDvA++;
                expDataA = word;
                expWordsA.push_back(word);
            end
        end
    endtask

    // Lets the line idle, then compares every accumulated total and held output.
    task automatic settle(input int p, input string tag);
        ticks(2 * p + 8);
        #1;
        checkOutput({tag, " dvA"},   dvCntA, expDvA);
        checkOutput({tag, " peA"},   peCntA, expPeA);
        checkOutput({tag, " seA"},   seCntA, expSeA);
        checkOutput({tag, " dataA"}, {1'b0, pDataA}, expDataA);
        checkOutput({tag, " busyA"}, busyA, 1'b0);
        checkOutput({tag, " dvB"},   dvCntB, expDvB);
        checkOutput({tag, " peB"},   peCntB, expPeB);
        checkOutput({tag, " seB"},   seCntB, expSeB);
        checkOutput({tag, " dataB"}, {2'b0, pDataB}, expDataB);
        checkOutput({tag, " busyB"}, busyB, 1'b0);
        while (rdA < gotA.size() && rdA < expWordsA.size()) begin
            checkOutput($sformatf("%s wordA[%0d]", tag, rdA), gotA[rdA], expWordsA[rdA]);
            rdA++;
        end
    endtask

    initial begin
        logic [7:0] w77;
        w77      = 8'h77;
        rst      = 1'b1;
        line     = 1'b1;
        selB     = 1'b0;
        prescale = PRESC_W'(8);
        parEn    = 1'b0;
        parTyp   = 1'b0;
        stop2    = 1'b0;
        ticks(3);
        #1;
        checkOutput("reset dataA", {1'b0, pDataA}, 9'h0);
        checkOutput("reset dvA",   dvA,   1'b0);
        checkOutput("reset busyA", busyA, 1'b0);
        checkOutput("reset errA",  {peA, seA}, 2'b00);
        checkOutput("reset busyB", busyB, 1'b0);
        rst = 1'b0;
        ticks(4);

        applyStimulus(0, 8, 9'hA5, 8, 0, 0, 0, 0, -1, 0);
        settle(8, "A5 p8");
        applyStimulus(0, 8, 9'h3C, 16, 1, 0, 0, 1, -1, 0);
        settle(16, "3C badpar");
        applyStimulus(1, 7, 9'h55, 32, 1, 1, 1, 0, 1, 0);
        settle(32, "55 stop2 low");

        prescale = PRESC_W'(16);
        parEn    = 1'b0;
        stop2    = 1'b0;
        line     = 1'b0;
        ticks(3);
        line = 1'b1;
        settle(16, "glitch");
        applyStimulus(0, 8, 9'h81, 16, 0, 0, 0, 0, -1, 0);
        settle(16, "81 after glitch");

        applyStimulus(0, 8, 9'h01, 8, 0, 0, 0, 0, -1, 1);
        applyStimulus(0, 8, 9'hFE, 8, 0, 0, 0, 0, -1, 0);
        settle(8, "b2b p8");
        applyStimulus(0, 8, 9'h5A, 16, 1, 1, 0, 0, -1, 1);
        applyStimulus(0, 8, 9'hC3, 16, 1, 0, 1, 0, -1, 0);
        settle(16, "b2b p16");

        selB     = 1'b0;
        prescale = PRESC_W'(16);
        parEn    = 1'b0;
        stop2    = 1'b0;
        line     = 1'b0;
        ticks(16);
        for (int i = 0; i < 3; i++) begin
            line = w77[i];
            ticks(16);
        end
        #1;
        checkOutput("busy mid-frame", busyA, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("rst busyA", busyA, 1'b0);
        checkOutput("rst dataA", {1'b0, pDataA}, 9'h0);
        checkOutput("rst pulsesA", {dvA, peA, seA}, 3'b000);
        ticks(2);
        rst      = 1'b0;
        line     = 1'b1;
        expDataA = '0;
        expDataB = '0;
        settle(16, "after reset");
        applyStimulus(0, 8, 9'h12, 16, 0, 0, 0, 0, -1, 0);
        settle(16, "12 after reset");

        for (int n = 0; n < 40; n++) begin
            bit toB;
            int p;
            bit pe;
            bit pt;
            bit s2;
            bit bad;
            int sl;
            logic [8:0] d;
            toB = (n % 4 == 3);
            p   = 8 << $urandom_range(0, 2);
            pe  = 1'($urandom);
            pt  = 1'($urandom);
            s2  = 1'($urandom);
            bad = pe && ($urandom_range(0, 3) == 0);
            sl  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, s2 ? 1 : 0)) : -1;
            d   = 9'($urandom);
            applyStimulus(toB, toB ? 7 : 8, d, p, pe, pt, s2, bad, sl, 0);
            settle(p, $sformatf("rand%0d", n));
        end

        checkOutput("valid with error overlap", overlapCnt, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
